// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with registered one-hot grant,
// encoded grant index and a hold timer that preempts a monopolising owner.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state,    w_next_state;
  logic [1:0]       r_owner,    w_next_owner;
  logic [1:0]       r_ptr,      w_next_ptr;
  logic [CNT_W-1:0] r_hold_cnt, w_next_hold_cnt;
  logic             r_preempt,  w_next_preempt;

  logic [3:0]       w_others;
  logic [2:0]       w_pick_all;
  logic [2:0]       w_pick_oth;

  // Returns {found, index} of the first set bit scanning p, p+1, p+2, p+3 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_others   = req & ~(4'b0001 << r_owner);
  assign w_pick_all = rr_pick(req, r_ptr);
  assign w_pick_oth = rr_pick(w_others, r_ptr);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= 2'd0;
      r_ptr      <= 2'd0;
      r_hold_cnt <= '0;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_owner    <= w_next_owner;
      r_ptr      <= w_next_ptr;
      r_hold_cnt <= w_next_hold_cnt;
      r_preempt  <= w_next_preempt;
    end
  end

  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next_state    = r_state;
    w_next_owner    = r_owner;
    w_next_ptr      = r_ptr;
    w_next_hold_cnt = r_hold_cnt;
    w_next_preempt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_all[2]) begin
          w_next_state    = BUSY;
          w_next_owner    = w_pick_all[1:0];
          w_next_ptr      = w_pick_all[1:0] + 2'd1;
          w_next_hold_cnt = '0;
        end
      end
      BUSY: begin
        if (req[r_owner] && !(r_hold_cnt == HOLD_LAST && w_pick_oth[2])) begin
          if (r_hold_cnt != HOLD_LAST) w_next_hold_cnt = r_hold_cnt + CNT_W'(1);
        end else if (w_pick_oth[2]) begin
          // Owner released or timed out with a competitor waiting: hand over now.
          w_next_owner    = w_pick_oth[1:0];
          w_next_ptr      = w_pick_oth[1:0] + 2'd1;
          w_next_hold_cnt = '0;
          w_next_preempt  = req[r_owner];
        end else begin
          w_next_state    = IDLE;
          w_next_hold_cnt = '0;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are pure decodes of flops; gnt_idx keeps the last owner while idle.
  always_comb begin
    gnt            = 4'b0000;
    if (r_state == BUSY) gnt[r_owner] = 1'b1;
    gnt_valid      = (r_state == BUSY);
    gnt_idx        = r_owner;
    preempt        = r_preempt;
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: stimulus pushes model predictions into a
// queue, a monitor pops and compares one entry after every clock edge.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 8;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       preempt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  // Reference model state: who owns the resource and for how many cycles.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cycles;
  int m_idx;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got gnt=%b idx=%b valid=%b preempt=%b, expected gnt=%b idx=%b valid=%b preempt=%b",
               name, $time, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [7:0] dut_out();
    return {gnt, gnt_idx, gnt_valid, preempt};
  endfunction

  function automatic void model_reset();
    m_busy   = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_cycles = 0;
    m_idx    = 0;
  endfunction

  // One clock edge of the arbiter's rules, written as "cycles owned so far".
  function automatic exp_t model_step(input logic [3:0] v);
    exp_t       e;
    logic [3:0] cand;
    bit         found;
    int         w;
    e.preempt = 1'b0;
    cand = v;
    if (m_busy) cand[m_owner] = 1'b0;
    if (m_busy && v[m_owner] && (m_cycles < MAX_HOLD || cand == 4'b0000)) begin
      m_cycles++;
    end else begin
      found = 1'b0;
      w = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && cand[(m_ptr + k) % 4]) begin
          found = 1'b1;
          w = (m_ptr + k) % 4;
        end
      end
      if (found) begin
        e.preempt = m_busy && v[m_owner];
        m_busy    = 1'b1;
        m_owner   = w;
        m_idx     = w;
        m_ptr     = (w + 1) % 4;
        m_cycles  = 1;
      end else begin
        m_busy = 1'b0;
      end
    end
    e.gnt   = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    e.idx   = 2'(m_idx);
    e.valid = m_busy;
    return e;
  endfunction

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    req = v;
    q.push_back(model_step(v));
  endtask

  // Asynchronous reset asserted and released between clock edges.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_out(), 8'h00);
    model_reset();
    req = 4'b0000;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: one prediction per clock edge while any are outstanding.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("grant", dut_out(), e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    #2;
    check("reset_state", dut_out(), 8'h00);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Idle, then single requester grant and release.
    repeat (5) drive(4'b0000);
    drive(4'b0100);
    drive(4'b0000);
    drive(4'b0000);

    // Rotation with every owner releasing after one cycle.
    do_reset();
    drive(4'b1111);
    drive(4'b1110);
    drive(4'b1101);
    drive(4'b1011);
    drive(4'b0111);
    drive(4'b0000);

    // Hold timeout with a late competitor.
    do_reset();
    repeat (3) drive(4'b0001);
    repeat (12) drive(4'b0101);
    drive(4'b0000);

    // Lone owner keeps the grant, then is preempted at once.
    repeat (20) drive(4'b1000);
    repeat (3) drive(4'b1001);
    drive(4'b0000);

    // Reset mid-grant, then pointer starts at zero again.
    do_reset();
    drive(4'b0010);
    drive(4'b0010);
    do_reset();
    drive(4'b1111);
    drive(4'b0000);

    // Sticky random requests so long holds and preemptions occur.
    r = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      if (i % 700 == 350) do_reset();
      drive(r);
    end
    drive(4'b0000);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 8'(q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
